// File: rtl/frequency_counter_multi.sv
// Multi-channel gated edge counter with a multiplexed hex display of one channel.
module frequency_counter_multi #(
  parameter  int NUM_CH         = 4,
  parameter  int COUNT_W        = 16,
  parameter  int PERIOD_W       = 16,
  parameter  int PERIOD_DEFAULT = 1000,
  parameter  int DIGITS         = 2,
  parameter  int SCAN_W         = 10,
  parameter  int SYNC_STAGES    = 2,
  localparam int CH_SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   signal,
  input  logic                period_load,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CH_SEL_W-1:0] ch_sel,
  input  logic                hold,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   digit,
  output logic                window_done,
  output logic [NUM_CH-1:0]   overflow
);

  logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]   prev_q;
  logic [NUM_CH-1:0]   edge_p;
  logic [NUM_CH-1:0]   sat;
  logic [NUM_CH-1:0]   ovf;
  logic [COUNT_W-1:0]  count     [NUM_CH];
  logic [COUNT_W-1:0]  count_nxt [NUM_CH];
  logic [COUNT_W-1:0]  result    [NUM_CH];
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] timer;
  logic                terminal;

  logic [SCAN_W-1:0]   scan_q;
  logic [1:0]          dig_idx;
  logic [1:0]          next_idx;
  logic                wrap;
  logic [CH_SEL_W-1:0] sel_ch;
  logic [COUNT_W-1:0]  shown;
  logic                dash;
  logic [3:0]          nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= signal;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_p   = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign terminal = (timer == period_reg - PERIOD_W'(1));

  always_comb begin
    sat = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      count_nxt[i] = count[i];
      sat[i]       = edge_p[i] && (count[i] == '1);
      if (edge_p[i] && !sat[i]) count_nxt[i] = count[i] + COUNT_W'(1);
    end
  end

  // the closing window's last edge is folded in via count_nxt/sat at latch time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_reg  <= PERIOD_W'(PERIOD_DEFAULT);
      timer       <= '0;
      window_done <= 1'b0;
      ovf         <= '0;
      overflow    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        result[i] <= '0;
      end
    end else if (period_load) begin
      period_reg  <= (period == '0) ? PERIOD_W'(1) : period;
      timer       <= '0;
      window_done <= 1'b0;
      ovf         <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) count[i] <= '0;
    end else begin
      window_done <= terminal;
      if (terminal) begin
        timer <= '0;
        ovf   <= '0;
        if (!hold) overflow <= ovf | sat;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          count[i] <= '0;
          if (!hold) result[i] <= count_nxt[i];
        end
      end else begin
        timer <= timer + PERIOD_W'(1);
        ovf   <= ovf | sat;
        for (int unsigned i = 0; i < NUM_CH; i++) count[i] <= count_nxt[i];
      end
    end
  end

  generate
    if ((1 << CH_SEL_W) > NUM_CH) begin : g_clamp
      assign sel_ch = (32'(ch_sel) < NUM_CH) ? ch_sel : '0;
    end else begin : g_direct
      assign sel_ch = ch_sel;
    end
  endgenerate

  assign wrap     = (scan_q == '1);
  assign next_idx = (dig_idx == 2'(DIGITS - 1)) ? 2'd0 : dig_idx + 2'd1;
  assign shown    = result[sel_ch];
  assign dash     = overflow[sel_ch] || ((shown >> (4 * DIGITS)) != '0);
  assign nibble   = 4'(shown >> {next_idx, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q   <= '0;
      dig_idx  <= 2'd0;
      digit    <= DIGITS'(1);
      segments <= 7'b0111111;
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
      if (wrap) begin
        dig_idx  <= next_idx;
        digit    <= DIGITS'(1) << next_idx;
        segments <= dash ? 7'b1000000 : hex7(nibble);
      end
    end
  end

endmodule
